// File: rtl/pipe_pkg.sv
// Shared encodings for the RV64I+Zba pipeline: result-source select,
// ALU operation codes and the operand forwarding select.
package pipe_pkg;

  // Writeback result source
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  // ALU operation codes; ALU_ADD must stay 0 so a bubble decodes as add
  localparam logic [4:0] ALU_ADD      = 5'b00000;
  localparam logic [4:0] ALU_SUB      = 5'b00001;
  localparam logic [4:0] ALU_SLL      = 5'b00010;
  localparam logic [4:0] ALU_SLT      = 5'b00011;
  localparam logic [4:0] ALU_SLTU     = 5'b00100;
  localparam logic [4:0] ALU_XOR      = 5'b00101;
  localparam logic [4:0] ALU_SRL      = 5'b00110;
  localparam logic [4:0] ALU_SRA      = 5'b00111;
  localparam logic [4:0] ALU_OR       = 5'b01000;
  localparam logic [4:0] ALU_AND      = 5'b01001;
  localparam logic [4:0] ALU_ADDW     = 5'b01010;
  localparam logic [4:0] ALU_SUBW     = 5'b01011;
  localparam logic [4:0] ALU_SLLW     = 5'b01100;
  localparam logic [4:0] ALU_SRLW     = 5'b01101;
  localparam logic [4:0] ALU_SRAW     = 5'b01110;
  localparam logic [4:0] ALU_SH1ADD   = 5'b01111;
  localparam logic [4:0] ALU_SH2ADD   = 5'b10000;
  localparam logic [4:0] ALU_SH3ADD   = 5'b10001;
  localparam logic [4:0] ALU_ADDUW    = 5'b10010;
  localparam logic [4:0] ALU_SH1ADDUW = 5'b10011;
  localparam logic [4:0] ALU_SH2ADDUW = 5'b10100;
  localparam logic [4:0] ALU_SLLIUW   = 5'b10101;
  localparam logic [4:0] ALU_SH3ADDUW = 5'b10110;

  // Operand forwarding source
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding: match an E-stage source index against the MEM and
// WB destinations and pick the youngest producer. x0 is never forwarded.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] rs_i,
  input  logic [XLEN-1:0] reg_data_i,
  input  logic [REGW-1:0] rd_m_i,
  input  logic            regwrite_m_i,
  input  logic [XLEN-1:0] alu_result_m_i,
  input  logic [REGW-1:0] rd_w_i,
  input  logic            regwrite_w_i,
  input  logic [XLEN-1:0] result_w_i,
  output logic [XLEN-1:0] data_o
);

  fwd_sel_e sel;

  // Match logic: MEM is younger than WB, so it wins on a double hit
  always_comb begin
    sel = FWD_REG;
    if (regwrite_m_i && (rd_m_i != '0) && (rd_m_i == rs_i))
      sel = FWD_MEM;
    else if (regwrite_w_i && (rd_w_i != '0) && (rd_w_i == rs_i))
      sel = FWD_WB;
  end

  // 3:1 data select
  always_comb begin
    unique case (sel)
      FWD_MEM: data_o = alu_result_m_i;
      FWD_WB:  data_o = result_w_i;
      default: data_o = reg_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// A load-use hazard or a flush inserts an all-zero bubble into E.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [REGW-1:0] Rs1D,
  input  logic [REGW-1:0] Rs2D,
  input  logic [REGW-1:0] RdD,
  input  logic [4:0]      ALUControlD,
  input  logic            ALUSrcD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic [1:0]      ResultSrcD,
  input  logic            ValidD,
  input  logic            FlushE,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [REGW-1:0] RdM,
  input  logic            RegWriteM,
  input  logic [XLEN-1:0] ResultW,
  input  logic [REGW-1:0] RdW,
  input  logic            RegWriteW,
  output logic            StallD,
  output logic [XLEN-1:0] SrcAE,
  output logic [XLEN-1:0] SrcBE,
  output logic [4:0]      ALUControlE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCE,
  output logic [REGW-1:0] RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            ValidE
);

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memwrite;
    logic            alusrc;
    logic [1:0]      resultsrc;
    logic [4:0]      aluctrl;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } ex_t;

  ex_t             ex_q, ex_d;
  logic            bubble;
  logic [XLEN-1:0] fwd_a, fwd_b;

  // Load-use: the load in E cannot supply data to D in time. Rs2D is compared
  // even for I-type, accepting an occasional needless stall.
  always_comb begin
    StallD = !reset && ex_q.valid && ex_q.regwrite && (ex_q.resultsrc == RES_LOAD) &&
             (ex_q.rd != '0) && ((ex_q.rd == Rs1D) || (ex_q.rd == Rs2D));
  end

  assign bubble = FlushE | StallD;

  // Next E contents: zero bubble (same as reset image) or the D-stage bundle
  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.valid     = ValidD;
      ex_d.regwrite  = RegWriteD;
      ex_d.memwrite  = MemWriteD;
      ex_d.alusrc    = ALUSrcD;
      ex_d.resultsrc = ResultSrcD;
      ex_d.aluctrl   = ALUControlD;
      ex_d.rs1       = Rs1D;
      ex_d.rs2       = Rs2D;
      ex_d.rd        = RdD;
      ex_d.rd1       = RD1D;
      ex_d.rd2       = RD2D;
      ex_d.imm       = ImmExtD;
      ex_d.pc        = PCD;
    end
  end

  // E-stage register; reset dominates flush and stall
  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_a (
    .rs_i(ex_q.rs1), .reg_data_i(ex_q.rd1),
    .rd_m_i(RdM), .regwrite_m_i(RegWriteM), .alu_result_m_i(ALUResultM),
    .rd_w_i(RdW), .regwrite_w_i(RegWriteW), .result_w_i(ResultW),
    .data_o(fwd_a)
  );

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_b (
    .rs_i(ex_q.rs2), .reg_data_i(ex_q.rd2),
    .rd_m_i(RdM), .regwrite_m_i(RegWriteM), .alu_result_m_i(ALUResultM),
    .rd_w_i(RdW), .regwrite_w_i(RegWriteW), .result_w_i(ResultW),
    .data_o(fwd_b)
  );

  assign SrcAE       = fwd_a;
  assign WriteDataE  = fwd_b;
  assign SrcBE       = ex_q.alusrc ? ex_q.imm : fwd_b;
  assign ALUControlE = ex_q.aluctrl;
  assign PCE         = ex_q.pc;
  assign RdE         = ex_q.rd;
  assign RegWriteE   = ex_q.regwrite;
  assign MemWriteE   = ex_q.memwrite;
  assign ResultSrcE  = ex_q.resultsrc;
  assign ValidE      = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus a randomized run against a
// behavioural model of the instruction held in E.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] RD1D, RD2D, ImmExtD, PCD, ALUResultM, ResultW;
  logic [4:0]  Rs1D, Rs2D, RdD, RdM, RdW, ALUControlD;
  logic        ALUSrcD, RegWriteD, MemWriteD, ValidD, FlushE, RegWriteM, RegWriteW;
  logic [1:0]  ResultSrcD;
  logic        StallD, RegWriteE, MemWriteE, ValidE;
  logic [63:0] SrcAE, SrcBE, WriteDataE, PCE;
  logic [4:0]  ALUControlE, RdE;
  logic [1:0]  ResultSrcE;

  int tests = 0;
  int fails = 0;

  // Model of the instruction sitting in E
  logic        m_valid, m_rw, m_mw, m_alusrc;
  logic [1:0]  m_rsrc;
  logic [4:0]  m_aluc, m_rs1, m_rs2, m_rd;
  logic [63:0] m_rd1, m_rd2, m_imm, m_pc;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD), .ValidD(ValidD),
    .FlushE(FlushE), .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .StallD(StallD), .SrcAE(SrcAE),
    .SrcBE(SrcBE), .ALUControlE(ALUControlE), .WriteDataE(WriteDataE), .PCE(PCE), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .ValidE(ValidE)
  );

  always #5 clk = ~clk;

  // Value an instruction reading register rs actually sees this cycle
  function automatic logic [63:0] see_reg(input logic [4:0] rs, input logic [63:0] rf);
    if (rs == 0) return rf;
    if (RegWriteM && RdM == rs) return ALUResultM;
    if (RegWriteW && RdW == rs) return ResultW;
    return rf;
  endfunction

  // D must wait when E is a live load whose destination D reads
  function automatic logic want_stall();
    return !reset && m_valid && m_rw && m_rsrc == RES_LOAD && m_rd != 0 &&
           (m_rd == Rs1D || m_rd == Rs2D);
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge
  task automatic tick();
    if (reset || FlushE || want_stall()) begin
      {m_valid, m_rw, m_mw, m_alusrc, m_rsrc, m_aluc} = '0;
      {m_rs1, m_rs2, m_rd, m_rd1, m_rd2, m_imm, m_pc} = '0;
    end else begin
      m_valid = ValidD; m_rw = RegWriteD; m_mw = MemWriteD; m_alusrc = ALUSrcD;
      m_rsrc = ResultSrcD; m_aluc = ALUControlD; m_rs1 = Rs1D; m_rs2 = Rs2D; m_rd = RdD;
      m_rd1 = RD1D; m_rd2 = RD2D; m_imm = ImmExtD; m_pc = PCD;
    end
    @(posedge clk); #1;
  endtask

  task automatic clr_in();
    {RD1D, RD2D, ImmExtD, PCD, ALUResultM, ResultW} = '0;
    {Rs1D, Rs2D, RdD, RdM, RdW, ALUControlD} = '0;
    {ALUSrcD, RegWriteD, MemWriteD, ValidD, FlushE, RegWriteM, RegWriteW, ResultSrcD} = '0;
  endtask

  task automatic test_reset();
    clr_in();
    reset = 1'b1;
    RD1D = 64'h11; RD2D = 64'h22; ImmExtD = 64'h33; PCD = 64'h1000;
    Rs1D = 5'd3; Rs2D = 5'd4; RdD = 5'd3; ALUControlD = ALU_SUB;
    RegWriteD = 1; MemWriteD = 1; ResultSrcD = RES_LOAD; ValidD = 1; ALUSrcD = 1;
    tick(); tick();
    tests++;
    if ({ValidE, RegWriteE, MemWriteE, ResultSrcE, RdE, ALUControlE, PCE, SrcAE, SrcBE, WriteDataE} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b rw=%b mw=%b rs=%b rd=%0d alu=%0d pc=%h a=%h b=%h wd=%h, want all 0",
               ValidE, RegWriteE, MemWriteE, ResultSrcE, RdE, ALUControlE, PCE, SrcAE, SrcBE, WriteDataE);
    end
    tests++;
    if (StallD !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", StallD); end
    reset = 1'b0;
    tick();
    tests++;
    if (ValidE !== 1'b1 || PCE !== 64'h1000 || RdE !== 5'd3 || ALUControlE !== ALU_SUB) begin
      fails++;
      $display("FAIL reset_first_capture: got valid=%b pc=%h rd=%0d alu=%0d want 1 1000 3 1", ValidE, PCE, RdE, ALUControlE);
    end
    clr_in(); tick();
  endtask

  task automatic test_forward();
    clr_in();
    Rs1D = 5'd5; RD1D = 64'h777; ValidD = 1;
    tick();
    RegWriteM = 1; RdM = 5'd5; ALUResultM = 64'h1234;
    RegWriteW = 1; RdW = 5'd5; ResultW = 64'hFFFF;
    #1 tests++;
    if (SrcAE !== 64'h1234) begin fails++; $display("FAIL fwd_mem_priority: got %h want 1234", SrcAE); end
    RegWriteM = 0;
    #1 tests++;
    if (SrcAE !== 64'hFFFF) begin fails++; $display("FAIL fwd_wb: got %h want ffff", SrcAE); end
    RegWriteW = 0;
    #1 tests++;
    if (SrcAE !== 64'h777) begin fails++; $display("FAIL fwd_none: got %h want 777", SrcAE); end
    clr_in(); tick();
  endtask

  task automatic test_x0();
    clr_in();
    Rs1D = 5'd0; RD1D = 64'h0; ValidD = 1;
    tick();
    RegWriteM = 1; RdM = 5'd0; ALUResultM = 64'hDEAD;
    RegWriteW = 1; RdW = 5'd0; ResultW = 64'hBEEF;
    #1 tests++;
    if (SrcAE !== 64'h0) begin fails++; $display("FAIL x0_guard: got %h want 0", SrcAE); end
    clr_in(); tick();
  endtask

  task automatic test_load_use();
    clr_in();
    ValidD = 1; RegWriteD = 1; ResultSrcD = RES_LOAD; RdD = 5'd7;
    tick();
    clr_in();
    ValidD = 1; Rs1D = 5'd1; Rs2D = 5'd7; PCD = 64'h100; RegWriteD = 1; RdD = 5'd9;
    #1 tests++;
    if (StallD !== 1'b1) begin fails++; $display("FAIL loaduse_stall: got %b want 1", StallD); end
    tick();
    tests++;
    if (ValidE !== 1'b0 || RegWriteE !== 1'b0 || StallD !== 1'b0) begin
      fails++;
      $display("FAIL loaduse_bubble: got valid=%b rw=%b stall=%b want 0 0 0", ValidE, RegWriteE, StallD);
    end
    tick();
    tests++;
    if (ValidE !== 1'b1 || PCE !== 64'h100 || RdE !== 5'd9) begin
      fails++;
      $display("FAIL loaduse_release: got valid=%b pc=%h rd=%0d want 1 100 9", ValidE, PCE, RdE);
    end
    clr_in(); tick();
  endtask

  task automatic test_flush();
    clr_in();
    ValidD = 1; RegWriteD = 1; MemWriteD = 1; ALUControlD = ALU_ADD; RdD = 5'd4; FlushE = 1;
    tick();
    tests++;
    if (ValidE !== 1'b0 || RegWriteE !== 1'b0 || MemWriteE !== 1'b0) begin
      fails++;
      $display("FAIL flush_bubble: got valid=%b rw=%b mw=%b want 0 0 0", ValidE, RegWriteE, MemWriteE);
    end
    clr_in();
    ValidD = 1; RegWriteD = 1; ResultSrcD = RES_LOAD; RdD = 5'd7;
    tick();
    clr_in();
    ValidD = 1; Rs1D = 5'd7; PCD = 64'h200; FlushE = 1;
    #1 tests++;
    if (StallD !== 1'b1) begin fails++; $display("FAIL flush_stall_assert: got %b want 1", StallD); end
    tick();
    tests++;
    if (ValidE !== 1'b0) begin fails++; $display("FAIL flush_stall_bubble: got valid=%b want 0", ValidE); end
    FlushE = 0;
    tick();
    tests++;
    if (ValidE !== 1'b1 || PCE !== 64'h200) begin
      fails++;
      $display("FAIL flush_stall_single: got valid=%b pc=%h want 1 200", ValidE, PCE);
    end
    clr_in(); tick();
  endtask

  task automatic test_imm();
    clr_in();
    ValidD = 1; Rs2D = 5'd9; RD2D = 64'h11; ALUSrcD = 1; ImmExtD = 64'hFFFF_FFFF_FFFF_FFF0;
    tick();
    RegWriteM = 1; RdM = 5'd9; ALUResultM = 64'h55;
    #1 tests++;
    if (SrcBE !== 64'hFFFF_FFFF_FFFF_FFF0 || WriteDataE !== 64'h55) begin
      fails++;
      $display("FAIL imm_path: got srcb=%h wd=%h want fffffffffffffff0 55", SrcBE, WriteDataE);
    end
    clr_in(); tick();
  endtask

  task automatic test_random();
    logic [63:0] ea, eb;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      FlushE = ($urandom_range(0, 9) == 0);
      ValidD = $urandom; RegWriteD = $urandom; MemWriteD = $urandom; ALUSrcD = $urandom;
      ResultSrcD = 2'($urandom_range(0, 2)); ALUControlD = 5'($urandom_range(0, 22));
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7)); RdD = 5'($urandom_range(0, 7));
      RD1D = {$urandom, $urandom}; RD2D = {$urandom, $urandom};
      ImmExtD = {$urandom, $urandom}; PCD = {$urandom, $urandom};
      RegWriteM = $urandom; RdM = 5'($urandom_range(0, 7)); ALUResultM = {$urandom, $urandom};
      RegWriteW = $urandom; RdW = 5'($urandom_range(0, 7)); ResultW = {$urandom, $urandom};
      #1;
      ea = see_reg(m_rs1, m_rd1);
      eb = see_reg(m_rs2, m_rd2);
      tests++;
      if (StallD !== want_stall()) begin
        fails++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, StallD, want_stall());
      end
      tests++;
      if (SrcAE !== ea || WriteDataE !== eb || SrcBE !== (m_alusrc ? m_imm : eb)) begin
        fails++;
        $display("FAIL rnd_operands[%0d]: got a=%h b=%h wd=%h want a=%h b=%h wd=%h",
                 i, SrcAE, SrcBE, WriteDataE, ea, (m_alusrc ? m_imm : eb), eb);
      end
      tests++;
      if ({ValidE, RegWriteE, MemWriteE, ResultSrcE, ALUControlE, RdE, PCE} !==
          {m_valid, m_rw, m_mw, m_rsrc, m_aluc, m_rd, m_pc}) begin
        fails++;
        $display("FAIL rnd_ctrl[%0d]: got v=%b rw=%b mw=%b rs=%b alu=%0d rd=%0d pc=%h want v=%b rw=%b mw=%b rs=%b alu=%0d rd=%0d pc=%h",
                 i, ValidE, RegWriteE, MemWriteE, ResultSrcE, ALUControlE, RdE, PCE,
                 m_valid, m_rw, m_mw, m_rsrc, m_aluc, m_rd, m_pc);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    {m_valid, m_rw, m_mw, m_alusrc, m_rsrc, m_aluc} = '0;
    {m_rs1, m_rs2, m_rd, m_rd1, m_rd2, m_imm, m_pc} = '0;
    #2;
    test_reset();
    test_forward();
    test_x0();
    test_load_use();
    test_flush();
    test_imm();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
